ibex_mult_pext_issue: RTL
=========================

Name: ibex_mult_pext_issue

Overview:
Initiator-side sequencer for the P-extension multiplier (ZPN multiply/MAC ops).
- Accepts one multiply request per transaction from the ID/EX stage over a valid/ready handshake.
- Registers the operands and drives the multiplier's enable/operator/operand interface for the op-dependent number of cycles.
- Captures the multiplier result and holds it in a response register until writeback accepts it.
- Sits between the ID/EX issue logic and the multiplier; the multiplier itself is unchanged.

Parameters:
TimeoutCycles, 8, max cycles to wait for mult_valid_i on the final sequence cycle before flagging error_o; 0 disables the timeout.

Ports:
clk_i  input  1  clock
rst_ni  input  1  synchronous active-low reset
req_valid_i  input  1  request valid
req_ready_o  output  1  request accepted when valid&ready
req_operator_i  input  zpn_op_e  ZPN operation
req_op_a_i  input  32  rs1 value
req_op_b_i  input  32  rs2 value
req_rd_val_i  input  32  rd value for MAC ops
flush_i  input  1  abort in-flight op (pipeline flush)
mult_en_o  output  1  multiplier step enable
mult_operator_o  output  zpn_op_e  operator held for whole sequence
mult_width32_o  output  1  32-bit element op
mult_width8_o  output  1  8-bit element op
mult_signed_ops_o  output  1  signed op
mult_op_a_o  output  32  operand A, registered
mult_op_b_o  output  32  operand B, registered
mult_rd_val_o  output  32  rd value, registered
mult_result_i  input  32  multiplier result
mult_valid_i  input  1  multiplier result valid
rsp_valid_o  output  1  response valid
rsp_ready_i  input  1  writeback accepts response
rsp_result_o  output  32  captured result
busy_o  output  1  state != IDLE
error_o  output  1  one-cycle pulse on timeout

Behaviour:
- Reset: synchronous, active-low. While rst_ni=0 the following are forced at the next edge and held:
  - state=IDLE
  - rsp_valid_o=0, mult_en_o=0, error_o=0, busy_o=0
  - rsp_result_o=0, mult_op_a_o/b_o/rd_val_o=0
  - mult_operator_o = default operator
  - req_ready_o=0 while rst_ni low.
  - Reset mid-sequence discards the op; no response is produced.
- Cycle class from operator (decode sub-module):
  - SINGLE=1 cycle: 8x8, 16x16, 32x16 non-MAC.
  - DOUBLE=2 cycles: 32x32 non-MAC, any 8x8/16x16/32x16 MAC.
  - TRIPLE=3 cycles: 32x32 MAC (KMMAC/KMMSB/MADDR32/MSUBR32 and u-variants).
- Width/sign flags come from the same decode:
  - width8 for SMAQA/UMAQA/KHM8/KHMX8.
  - width32 for 32x32 and 32x16 ops.
  - signed_ops=0 only for UMAQA.
- FSM IDLE -> RUN -> RESP -> IDLE:
  - IDLE: req_ready_o=1. On valid&ready, register operator, operands and class; load step counter = class-1. Next state RUN.
  - RUN: mult_en_o=1 every cycle; counter decrements each cycle. Operands and operator are stable throughout RUN.
  - On the cycle counter==0 and mult_valid_i=1: capture mult_result_i into rsp_result_o and go to RESP. If mult_valid_i=0, stay in RUN with mult_en_o=0 and wait.
  - Timeout: waiting longer than TimeoutCycles asserts error_o for 1 cycle and returns to IDLE without a response.
  - RESP: rsp_valid_o=1, result held stable. On rsp_ready_i go to IDLE.
  - rsp_valid_o must not drop without rsp_ready_i.
- Latency: request accept to rsp_valid_o = class cycles + 1 with mult_valid_i always high, i.e. 2/3/4 cycles.
- No back-to-back acceptance: req_ready_o=0 in RUN and RESP. Same-cycle rsp handshake and new request are not possible (ready asserts the cycle after RESP exits).
- flush_i:
  - In RUN or RESP: next state IDLE, rsp_valid_o=0, counter cleared. This overrides capture in the same cycle.
  - In IDLE: req_ready_o=0 for that cycle; no accept.
- Simultaneous flush_i and rst_ni=0: reset wins (identical outcome).
- Counter width is 2 bits. It never wraps: it only decrements in RUN when it is nonzero.

Decomposition:
- ibex_pkg_pext gains:
  - typedef enum mult_pext_class_e {MC_SINGLE, MC_DOUBLE, MC_TRIPLE}
  - typedef enum mult_pext_issue_fsm_e {MI_IDLE, MI_RUN, MI_RESP}
- One combinational sub-module, ibex_mult_pext_op_decode: operator -> class, width32, width8, signed_ops. It is reused by the decoder and the multiplier.

Test Plan:
- SMBB16, a=0x0000_0003, b=0x0000_0004; stub returns 0x0000_000C with mult_valid_i=1 -> mult_en_o high 1 cycle, rsp_valid_o=1 at accept+2, rsp_result_o=0x0000_000C, width32=0, width8=0.
- SMMUL, a=b=0x4000_0000; stub returns 0x1000_0000 -> mult_en_o high exactly 2 cycles, operands stable, rsp at accept+3, result 0x1000_0000, width32=1.
- KMMAC, rd=0x0000_0001; stub returns 0x1000_0001 -> 3 enable cycles, mult_rd_val_o=0x0000_0001 throughout, rsp at accept+4.
- Backpressure: rsp_ready_i=0 for 5 cycles -> rsp_valid_o and rsp_result_o held, req_ready_o=0; the new request is accepted only the cycle after rsp_ready_i=1.
- flush_i in the 2nd RUN cycle of SMMUL -> no response, IDLE next cycle, req_ready_o=1 one cycle later. Same test mid-RESP -> rsp_valid_o drops.
- mult_valid_i held 0 with TimeoutCycles=8 -> error_o pulses once 8 cycles after the last step, IDLE, no rsp. Assert rst_ni=0 mid-RUN -> all outputs 0 at next edge.

Source files
------------

// File: rtl/ibex_mult_pext_issue_pkg.sv
// Purpose: shared types for the P-extension multiply issue path (operators, cycle classes, FSM states).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: zpn_op_e operator encoding, mult_pext_class_e step classes,
//           mult_pext_issue_fsm_e sequencer states, class -> step-counter helper.
package ibex_mult_pext_issue_pkg;

   // ZPN multiply/MAC operators handled by the P-extension multiplier.
   typedef enum logic [4:0] {
      ZPN_SMBB16  = 5'd0,
      ZPN_SMBT16  = 5'd1,
      ZPN_SMTT16  = 5'd2,
      ZPN_KHM16   = 5'd3,
      ZPN_KMABB   = 5'd4,
      ZPN_KMADA   = 5'd5,
      ZPN_KHM8    = 5'd6,
      ZPN_KHMX8   = 5'd7,
      ZPN_SMAQA   = 5'd8,
      ZPN_UMAQA   = 5'd9,
      ZPN_SMMWB   = 5'd10,
      ZPN_SMMWT   = 5'd11,
      ZPN_KMMAWB  = 5'd12,
      ZPN_KMMAWT  = 5'd13,
      ZPN_SMMUL   = 5'd14,
      ZPN_SMMULU  = 5'd15,
      ZPN_KMMAC   = 5'd16,
      ZPN_KMMACU  = 5'd17,
      ZPN_KMMSB   = 5'd18,
      ZPN_KMMSBU  = 5'd19,
      ZPN_MADDR32 = 5'd20,
      ZPN_MSUBR32 = 5'd21
   } zpn_op_e;

   // Operator presented to the multiplier when nothing is in flight.
   localparam zpn_op_e ZpnOpDefault = ZPN_SMBB16;

   typedef enum logic [1:0] {
      MC_SINGLE = 2'd0,
      MC_DOUBLE = 2'd1,
      MC_TRIPLE = 2'd2
   } mult_pext_class_e;

   typedef enum logic [1:0] {
      MI_IDLE = 2'd0,
      MI_RUN  = 2'd1,
      MI_RESP = 2'd2
   } mult_pext_issue_fsm_e;

   // Step counter preload: number of enable cycles minus one.
   function automatic logic [1:0] class_steps_m1(mult_pext_class_e cls);
      logic [1:0] steps;
      unique case (cls)
         MC_SINGLE: steps = 2'd0;
         MC_DOUBLE: steps = 2'd1;
         MC_TRIPLE: steps = 2'd2;
         default:   steps = 2'd0;
      endcase
      return steps;
   endfunction

endpackage

// File: rtl/ibex_mult_pext_op_decode.sv
// Purpose: decode a ZPN operator into its multiplier step class and element width/sign flags.
// Latency: combinational.
// Backpressure: none (pure function of operator_i).
// Ports: operator_i (zpn_op_e) -> class_o, width32_o (32x32/32x16), width8_o (8x8), signed_ops_o.
module ibex_mult_pext_op_decode
   import ibex_mult_pext_issue_pkg::*;
(
   input  zpn_op_e          operator_i,
   output mult_pext_class_e class_o,
   output logic             width32_o,
   output logic             width8_o,
   output logic             signed_ops_o
);

   always_comb begin
      class_o      = MC_SINGLE;
      width32_o    = 1'b0;
      width8_o     = 1'b0;
      signed_ops_o = 1'b1;
      unique case (operator_i)
         // 16x16 plain
         ZPN_SMBB16, ZPN_SMBT16, ZPN_SMTT16, ZPN_KHM16: begin
            class_o = MC_SINGLE;
         end
         // 16x16 accumulate
         ZPN_KMABB, ZPN_KMADA: begin
            class_o = MC_DOUBLE;
         end
         // 8x8 plain
         ZPN_KHM8, ZPN_KHMX8: begin
            class_o  = MC_SINGLE;
            width8_o = 1'b1;
         end
         // 8x8 accumulate; UMAQA is the only unsigned multiply in the set
         ZPN_SMAQA, ZPN_UMAQA: begin
            class_o      = MC_DOUBLE;
            width8_o     = 1'b1;
            signed_ops_o = (operator_i != ZPN_UMAQA);
         end
         // 32x16 plain
         ZPN_SMMWB, ZPN_SMMWT: begin
            class_o   = MC_SINGLE;
            width32_o = 1'b1;
         end
         // 32x16 accumulate
         ZPN_KMMAWB, ZPN_KMMAWT: begin
            class_o   = MC_DOUBLE;
            width32_o = 1'b1;
         end
         // 32x32 plain
         ZPN_SMMUL, ZPN_SMMULU: begin
            class_o   = MC_DOUBLE;
            width32_o = 1'b1;
         end
         // 32x32 accumulate
         ZPN_KMMAC, ZPN_KMMACU, ZPN_KMMSB, ZPN_KMMSBU, ZPN_MADDR32, ZPN_MSUBR32: begin
            class_o   = MC_TRIPLE;
            width32_o = 1'b1;
         end
         default: begin
            class_o = MC_SINGLE;
         end
      endcase
   end

endmodule

// File: rtl/ibex_mult_pext_issue.sv
// Purpose: issue sequencer between ID/EX and the P-extension multiplier; registers one op, steps it, holds the result.
// Latency: accept to rsp_valid_o = class steps + 1 (2/3/4 cycles) when mult_valid_i is high on the last step.
// Backpressure: one op in flight; req_ready_o low in RUN/RESP, response held until rsp_ready_i.
// Ports: clk_i/rst_ni (sync active-low); req_* issue handshake; flush_i abort;
//        mult_* multiplier drive and result return; rsp_* writeback handshake; busy_o, error_o (timeout pulse).
module ibex_mult_pext_issue
   import ibex_mult_pext_issue_pkg::*;
#(
   parameter int unsigned TimeoutCycles = 8
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  zpn_op_e     req_operator_i,
   input  logic [31:0] req_op_a_i,
   input  logic [31:0] req_op_b_i,
   input  logic [31:0] req_rd_val_i,
   input  logic        flush_i,
   output logic        mult_en_o,
   output zpn_op_e     mult_operator_o,
   output logic        mult_width32_o,
   output logic        mult_width8_o,
   output logic        mult_signed_ops_o,
   output logic [31:0] mult_op_a_o,
   output logic [31:0] mult_op_b_o,
   output logic [31:0] mult_rd_val_o,
   input  logic [31:0] mult_result_i,
   input  logic        mult_valid_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_result_o,
   output logic        busy_o,
   output logic        error_o
);

   localparam int unsigned WaitW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
   // Wait-counter value on the last permitted cycle without mult_valid_i.
   localparam logic [WaitW-1:0] WaitLast = WaitW'(TimeoutCycles - 1);

   mult_pext_issue_fsm_e state_q, state_d;
   zpn_op_e              op_q, op_d;
   logic [1:0]           cnt_q, cnt_d;
   logic [31:0]          a_q, a_d, b_q, b_d, rd_q, rd_d, res_q, res_d;
   logic                 w32_q, w32_d, w8_q, w8_d, sgn_q, sgn_d;
   logic                 waiting_q, waiting_d;
   logic [WaitW-1:0]     wait_cnt_q, wait_cnt_d;
   logic                 err_q, err_d;

   mult_pext_class_e     req_cls;
   logic                 req_w32, req_w8, req_sgn;
   logic                 accept;

   ibex_mult_pext_op_decode u_op_decode (
      .operator_i   (req_operator_i),
      .class_o      (req_cls),
      .width32_o    (req_w32),
      .width8_o     (req_w8),
      .signed_ops_o (req_sgn)
   );

   // A flush in IDLE blocks acceptance for that cycle.
   assign req_ready_o = rst_ni && (state_q == MI_IDLE) && !flush_i;
   assign accept      = req_valid_i && req_ready_o;

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      cnt_d      = cnt_q;
      a_d        = a_q;
      b_d        = b_q;
      rd_d       = rd_q;
      res_d      = res_q;
      w32_d      = w32_q;
      w8_d       = w8_q;
      sgn_d      = sgn_q;
      waiting_d  = waiting_q;
      wait_cnt_d = wait_cnt_q;
      err_d      = 1'b0;
      unique case (state_q)
         MI_IDLE: begin
            if (accept) begin
               op_d       = req_operator_i;
               a_d        = req_op_a_i;
               b_d        = req_op_b_i;
               rd_d       = req_rd_val_i;
               w32_d      = req_w32;
               w8_d       = req_w8;
               sgn_d      = req_sgn;
               cnt_d      = class_steps_m1(req_cls);
               waiting_d  = 1'b0;
               wait_cnt_d = '0;
               state_d    = MI_RUN;
            end
         end
         MI_RUN: begin
            // Flush has priority over a capture in the same cycle.
            if (flush_i) begin
               state_d    = MI_IDLE;
               cnt_d      = 2'd0;
               waiting_d  = 1'b0;
               wait_cnt_d = '0;
            end else if (cnt_q != 2'd0) begin
               cnt_d = cnt_q - 2'd1;
            end else if (mult_valid_i) begin
               res_d     = mult_result_i;
               waiting_d = 1'b0;
               state_d   = MI_RESP;
            end else if ((TimeoutCycles != 0) && (wait_cnt_q == WaitLast)) begin
               err_d      = 1'b1;
               waiting_d  = 1'b0;
               wait_cnt_d = '0;
               state_d    = MI_IDLE;
            end else begin
               // Final step issued but result not back: stop stepping and wait.
               waiting_d = 1'b1;
               if (TimeoutCycles != 0) begin
                  wait_cnt_d = wait_cnt_q + WaitW'(1);
               end
            end
         end
         MI_RESP: begin
            if (flush_i || rsp_ready_i) begin
               state_d = MI_IDLE;
            end
         end
         default: begin
            state_d = MI_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= MI_IDLE;
         op_q       <= ZpnOpDefault;
         cnt_q      <= 2'd0;
         a_q        <= 32'd0;
         b_q        <= 32'd0;
         rd_q       <= 32'd0;
         res_q      <= 32'd0;
         w32_q      <= 1'b0;
         w8_q       <= 1'b0;
         sgn_q      <= 1'b0;
         waiting_q  <= 1'b0;
         wait_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         cnt_q      <= cnt_d;
         a_q        <= a_d;
         b_q        <= b_d;
         rd_q       <= rd_d;
         res_q      <= res_d;
         w32_q      <= w32_d;
         w8_q       <= w8_d;
         sgn_q      <= sgn_d;
         waiting_q  <= waiting_d;
         wait_cnt_q <= wait_cnt_d;
         err_q      <= err_d;
      end
   end

   assign mult_en_o         = (state_q == MI_RUN) && !waiting_q;
   assign mult_operator_o   = op_q;
   assign mult_width32_o    = w32_q;
   assign mult_width8_o     = w8_q;
   assign mult_signed_ops_o = sgn_q;
   assign mult_op_a_o       = a_q;
   assign mult_op_b_o       = b_q;
   assign mult_rd_val_o     = rd_q;
   assign rsp_valid_o       = (state_q == MI_RESP);
   assign rsp_result_o      = res_q;
   assign busy_o            = (state_q != MI_IDLE);
   assign error_o           = err_q;

endmodule
